// File: rtl/seg_display_scanner_pkg.sv
// seg_display_pkg: segment vector type, blank pattern and hex decode table for 7-segment displays.
package seg_display_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    function automatic seg_t hex_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction
endpackage

// File: rtl/seg_display_scanner_if.sv
// seg_display_scanner_if: value/load request side and multiplexed segment/anode drive of the scanner.
interface seg_display_scanner_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_en;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    modport master (output value, load, dp_in, blank_en, input seg, dp, an);
    modport slave (input value, load, dp_in, blank_en, output seg, dp, an);
endinterface

// File: rtl/seg_display_scanner_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low {g..a} segment pattern.
module hex_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);
    assign seg = hex_seg(nib);
endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: double-buffered, dead-timed multiplexer of a packed hex value onto one 7-segment bus.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input logic clk,
    input logic rst_n,
    seg_display_scanner_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);
    localparam logic [IW-1:0] I_MAX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]                 pre;
    logic [IW-1:0]                 idx;
    logic [NUM_DIGITS-1:0][3:0]    act, pend;
    logic [NUM_DIGITS-1:0]         act_dp, pend_dp;
    logic                          pend_f;
    logic [NUM_DIGITS:0]           lz;
    logic                          wrap, bnd, dark;
    seg_t                          dec;

    assign wrap = pre == P_MAX;
    assign bnd  = wrap && idx == I_MAX;

    // lz[i]: digit i and every more-significant digit are zero
    always_comb begin
        lz = '0;
        lz[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            lz[i] = lz[i+1] && act[i] == 4'h0;
    end

    assign dark = pre < P_DEAD || (bus.blank_en && idx != '0 && lz[idx]);

    hex_to_seg u_dec (.nib(act[idx]), .seg(dec));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            idx     <= '0;
            act     <= '0;
            act_dp  <= '0;
            pend    <= '0;
            pend_dp <= '0;
            pend_f  <= 1'b0;
            bus.seg <= SEG_BLANK;
            bus.dp  <= 1'b1;
            bus.an  <= '1;
        end else begin
            pre <= wrap ? '0 : pre + 1'b1;
            if (wrap)
                idx <= idx == I_MAX ? '0 : idx + 1'b1;
            // a load in the boundary cycle bypasses the pending buffer
            if (bnd && (bus.load || pend_f)) begin
                act    <= bus.load ? bus.value : pend;
                act_dp <= bus.load ? bus.dp_in : pend_dp;
                pend_f <= 1'b0;
            end else if (bus.load) begin
                pend    <= bus.value;
                pend_dp <= bus.dp_in;
                pend_f  <= 1'b1;
            end
            bus.an  <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
            bus.seg <= dark ? SEG_BLANK : dec;
            bus.dp  <= dark ? 1'b1 : ~act_dp[idx];
        end
    end
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: directed and randomized checks of the scanner against a frame-time model.
module tb_seg_display_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    seg_display_scanner_if #(.NUM_DIGITS(4)) bus ();
    seg_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // model: k counts clocks since reset release; slot = k/8, digit = slot%4, frame = 32 clocks
    int          k = 0;
    int          last_k = -1;
    logic [15:0] m_act = '0, m_pend = '0;
    logic [3:0]  m_adp = '0, m_pdp = '0;
    bit          m_pf = 0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            k = 0; last_k = -1; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pf = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            int pos, dig;
            logic [3:0] nib;
            pos = k % 8;
            dig = (k / 8) % 4;
            nib = 4'((m_act >> (4 * dig)) & 16'hF);
            last_k = k;
            if (pos < 2 || (bus.blank_en && dig > 0 && (m_act >> (4 * dig)) == 0)) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an = ~(4'b1 << dig); e_seg = segtab[nib]; e_dp = ~m_adp[dig];
            end
            if (k % 32 == 31) begin
                if (bus.load) begin m_act = bus.value; m_adp = bus.dp_in; end
                else if (m_pf) begin m_act = m_pend; m_adp = m_pdp; end
                m_pf = 0;
            end else if (bus.load) begin
                m_pend = bus.value; m_pdp = bus.dp_in; m_pf = 1;
            end
            k++;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("an", 32'(bus.an), 32'(e_an));
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("dp", 32'(bus.dp), 32'(e_dp));
        chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
    end

    task automatic wait_k(input int target);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (last_k >= 0 && last_k % 32 == target) return;
        end
        chk("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        bus.value = v; bus.dp_in = d; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic lit(input string name, input logic [3:0] an, input logic [6:0] seg, input logic dp);
        chk({name, "_an"}, 32'(bus.an), 32'(an));
        chk({name, "_seg"}, 32'(bus.seg), 32'(seg));
        chk({name, "_dp"}, 32'(bus.dp), 32'(dp));
    endtask

    initial begin
        bus.value = '0; bus.dp_in = '0; bus.load = 1'b0; bus.blank_en = 1'b0;
        repeat (3) @(negedge clk);
        lit("reset", 4'hF, 7'h7F, 1'b1);
        rst_n = 1'b1;
        lit("dark0", 4'hF, 7'h7F, 1'b1);
        @(negedge clk); lit("dark1", 4'hF, 7'h7F, 1'b1);
        @(negedge clk); lit("dark2", 4'hF, 7'h7F, 1'b1);
        @(negedge clk); lit("first", 4'b1110, 7'h40, 1'b1);

        load_val(16'hA5F0, 4'b0100);
        wait_k(31); wait_k(4);
        lit("dec0", 4'b1110, 7'h40, 1'b1);
        wait_k(12); lit("dec1", 4'b1101, 7'h0E, 1'b1);
        wait_k(20); lit("dec2", 4'b1011, 7'h12, 1'b0);
        wait_k(28); lit("dec3", 4'b0111, 7'h08, 1'b1);

        wait_k(9); load_val(16'h1234, 4'b0000);
        wait_k(20); lit("tear_old2", 4'b1011, 7'h12, 1'b0);
        wait_k(28); lit("tear_old3", 4'b0111, 7'h08, 1'b1);
        wait_k(4);  lit("tear_new0", 4'b1110, 7'h19, 1'b1);
        wait_k(20); lit("tear_new2", 4'b1011, 7'h24, 1'b1);

        wait_k(5); load_val(16'h1111, 4'b0000); load_val(16'h2222, 4'b0000);
        wait_k(4);  lit("overwrite", 4'b1110, 7'h24, 1'b1);

        wait_k(30); load_val(16'h3333, 4'b0001);
        wait_k(4);  lit("bypass", 4'b1110, 7'h30, 1'b0);

        bus.blank_en = 1'b1;
        load_val(16'h0007, 4'b0000);
        wait_k(31); wait_k(4);
        lit("blank0", 4'b1110, 7'h78, 1'b1);
        wait_k(12); lit("blank1", 4'hF, 7'h7F, 1'b1);
        wait_k(28); lit("blank3", 4'hF, 7'h7F, 1'b1);
        load_val(16'h0000, 4'b0000);
        wait_k(31); wait_k(4);
        lit("zero0", 4'b1110, 7'h40, 1'b1);
        wait_k(12); lit("zero1", 4'hF, 7'h7F, 1'b1);
        bus.blank_en = 1'b0;
        wait_k(12); lit("noblank1", 4'b1101, 7'h40, 1'b1);

        load_val(16'h8888, 4'b0000);
        wait_k(31); wait_k(12);
        lit("pre_rst", 4'b1101, 7'h00, 1'b1);
        #2 rst_n = 1'b0;
        #1 lit("async_rst", 4'hF, 7'h7F, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        wait_k(2); lit("post_rst", 4'b1110, 7'h40, 1'b1);
        wait_k(12); lit("post_rst1", 4'b1101, 7'h40, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.load = ($urandom % 16) == 0;
            bus.value = ($urandom % 3 == 0) ? 16'($urandom % 256) : 16'($urandom);
            bus.dp_in = 4'($urandom);
            if ($urandom % 200 == 0) bus.blank_en = ~bus.blank_en;
        end
        bus.load = 1'b0;
        repeat (40) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
